// File: rtl/stage_writeback.sv
// stage_writeback: MEM/WB pipeline register and writeback logic of the MIPS core.
// Captures memory-stage results and extracts/extends load data per access type.
// Drives the register-file write port and tracks HALT retirement.
// Optional feature: define WB_RETIRE_CNT_EN to add the o_retired committed-instruction counter.
module stage_writeback #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic [NB_ADDR-1:0] i_write_reg,
    input  logic               is_RegWrite,
    input  logic               is_MemtoReg,
    input  logic [2:0]         is_load_store_type,
    input  logic               i_halt,
    output logic [NB_ADDR-1:0] o_addr_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               os_RegWrite,
    output logic               o_halted
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [NB_DATA-1:0] o_retired
`endif
);

    // Access-type encodings of is_load_store_type
    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    typedef struct packed {
        logic               valid;
        logic [NB_DATA-1:0] alu_result;
        logic [NB_DATA-1:0] mem_data;
        logic [NB_ADDR-1:0] write_reg;
        logic               reg_write;
        logic               mem_to_reg;
        logic [2:0]         load_store_type;
        logic               halt;
    } mem_wb_t;

    mem_wb_t     mem_wb;
    logic        halted;
    logic [1:0]  off;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [NB_DATA-1:0] load_data;

    // MEM/WB register: advances on enable unless the core has halted
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            mem_wb <= '0;
        end else if (i_enable && !halted) begin
            mem_wb <= '{
                valid:           i_valid,
                alu_result:      i_alu_result,
                mem_data:        i_mem_data,
                write_reg:       i_write_reg,
                reg_write:       is_RegWrite,
                mem_to_reg:      is_MemtoReg,
                load_store_type: is_load_store_type,
                halt:            i_halt
            };
        end
    end

    // Sticky halt flag: set on the edge after a valid HALT sits in MEM/WB
    always_ff @(posedge clk) begin
        if (i_reset) begin
            halted <= 1'b0;
        end else if (mem_wb.valid && mem_wb.halt) begin
            halted <= 1'b1;
        end
    end

    assign off       = mem_wb.alu_result[1:0];
    assign byte_lane = 8'(mem_wb.mem_data >> {off, 3'b000});
    assign half_lane = off[1] ? mem_wb.mem_data[31:16] : mem_wb.mem_data[15:0];

    // Load extraction: select the addressed lane and extend it per access type
    // NOTE: load_data gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        load_data = mem_wb.mem_data;
        case (mem_wb.load_store_type)
            LS_LB:   load_data = {{(NB_DATA-8){byte_lane[7]}}, byte_lane};
            LS_LBU:  load_data = {{(NB_DATA-8){1'b0}}, byte_lane};
            LS_LH:   load_data = {{(NB_DATA-16){half_lane[15]}}, half_lane};
            LS_LHU:  load_data = {{(NB_DATA-16){1'b0}}, half_lane};
            default: load_data = mem_wb.mem_data;
        endcase
    end

    assign o_addr_data = mem_wb.write_reg;
    assign o_data      = mem_wb.mem_to_reg ? load_data : mem_wb.alu_result;
    // Bubbles, writes to $0, HALT itself and anything after halting never reach the register file.
    assign os_RegWrite = mem_wb.valid && mem_wb.reg_write && (mem_wb.write_reg != '0)
                         && !mem_wb.halt && !halted;
    assign o_halted    = halted;

`ifdef WB_RETIRE_CNT_EN
    logic [NB_DATA-1:0] retired;

    // Committed-instruction counter: counts each non-HALT valid slot as it leaves MEM/WB
    always_ff @(posedge clk) begin
        if (i_reset) begin
            retired <= '0;
        end else if (i_enable && !halted && mem_wb.valid && !mem_wb.halt) begin
            retired <= retired + 1'b1;
        end
    end

    assign o_retired = retired;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// tb_stage_writeback: table-driven, scoreboard-checked bench for stage_writeback.
// Honors WB_RETIRE_CNT_EN the same way as the design.
module tb_stage_writeback;

    logic        clk;
    logic        i_reset;
    logic        i_enable;
    logic        i_valid;
    logic [31:0] i_alu_result;
    logic [31:0] i_mem_data;
    logic [4:0]  i_write_reg;
    logic        is_RegWrite;
    logic        is_MemtoReg;
    logic [2:0]  is_load_store_type;
    logic        i_halt;
    logic [4:0]  o_addr_data;
    logic [31:0] o_data;
    logic        os_RegWrite;
    logic        o_halted;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] o_retired;
`endif

    stage_writeback #(.NB_DATA(32), .NB_ADDR(5)) dut (
        .clk                (clk),
        .i_reset            (i_reset),
        .i_enable           (i_enable),
        .i_valid            (i_valid),
        .i_alu_result       (i_alu_result),
        .i_mem_data         (i_mem_data),
        .i_write_reg        (i_write_reg),
        .is_RegWrite        (is_RegWrite),
        .is_MemtoReg        (is_MemtoReg),
        .is_load_store_type (is_load_store_type),
        .i_halt             (i_halt),
        .o_addr_data        (o_addr_data),
        .o_data             (o_data),
        .os_RegWrite        (os_RegWrite),
        .o_halted           (o_halted)
`ifdef WB_RETIRE_CNT_EN
        ,
        .o_retired          (o_retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        valid;
        logic        halt;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  wr;
        logic        rw;
        logic        m2r;
        logic [2:0]  ls;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_we;
        logic        e_halted;
    } vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] MEMW = 32'h80FF_7F01;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic en, input logic valid,
                                input logic halt, input logic [31:0] alu, input logic [31:0] mem,
                                input logic [4:0] wr, input logic rw, input logic m2r,
                                input logic [2:0] ls, input logic [4:0] ea,
                                input logic [31:0] ed, input logic ew, input logic eh);
        vec_t v;
        v = '{rst, en, valid, halt, alu, mem, wr, rw, m2r, ls, ea, ed, ew, eh};
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expected response, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        i_reset            = v.rst;
        i_enable           = v.en;
        i_valid            = v.valid;
        i_halt             = v.halt;
        i_alu_result       = v.alu;
        i_mem_data         = v.mem;
        i_write_reg        = v.wr;
        is_RegWrite        = v.rw;
        is_MemtoReg        = v.m2r;
        is_load_store_type = v.ls;
        sb.push_back('{v.e_addr, v.e_data, v.e_we, v.e_halted});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " addr"},   32'(o_addr_data), 32'(e.addr));
            check({tag, " data"},   o_data,           e.data);
            check({tag, " we"},     32'(os_RegWrite), 32'(e.we));
            check({tag, " halted"}, 32'(o_halted),    32'(e.halted));
        end
    endtask

    vec_t tbl[16];

    initial begin
        // rst en vld hlt alu mem wr rw m2r ls | addr data we halted
        tbl[0]  = mk(0, 1, 1, 0, 32'h0000_1234, 32'h0,   5'd8,  1, 0, 3'b010, 5'd8,  32'h0000_1234, 1, 0); // ADD
        tbl[1]  = mk(0, 1, 1, 0, 32'h0000_0103, MEMW,    5'd10, 1, 1, 3'b000, 5'd10, 32'hFFFF_FF80, 1, 0); // LB off3
        tbl[2]  = mk(0, 1, 1, 0, 32'h0000_0103, MEMW,    5'd10, 1, 1, 3'b100, 5'd10, 32'h0000_0080, 1, 0); // LBU off3
        tbl[3]  = mk(0, 1, 1, 0, 32'h0000_0102, MEMW,    5'd11, 1, 1, 3'b001, 5'd11, 32'hFFFF_80FF, 1, 0); // LH off2
        tbl[4]  = mk(0, 1, 1, 0, 32'h0000_0100, MEMW,    5'd11, 1, 1, 3'b101, 5'd11, 32'h0000_7F01, 1, 0); // LHU off0
        tbl[5]  = mk(0, 1, 1, 0, 32'h0000_0101, MEMW,    5'd12, 1, 1, 3'b010, 5'd12, 32'h80FF_7F01, 1, 0); // LW off ignored
        tbl[6]  = mk(0, 1, 1, 0, 32'h0000_0101, MEMW,    5'd13, 1, 1, 3'b000, 5'd13, 32'h0000_007F, 1, 0); // LB off1
        tbl[7]  = mk(0, 1, 1, 0, 32'h0000_0102, MEMW,    5'd13, 1, 1, 3'b101, 5'd13, 32'h0000_80FF, 1, 0); // LHU off2
        tbl[8]  = mk(0, 1, 1, 0, 32'h0000_0100, MEMW,    5'd14, 1, 1, 3'b001, 5'd14, 32'h0000_7F01, 1, 0); // LH off0 positive
        tbl[9]  = mk(0, 1, 1, 0, 32'h0000_0102, MEMW,    5'd15, 1, 1, 3'b011, 5'd15, 32'h80FF_7F01, 1, 0); // other code
        tbl[10] = mk(0, 1, 1, 0, 32'h0000_0055, MEMW,    5'd0,  1, 0, 3'b010, 5'd0,  32'h0000_0055, 0, 0); // $0 write
        tbl[11] = mk(0, 1, 0, 0, 32'h0000_0066, MEMW,    5'd5,  1, 0, 3'b010, 5'd5,  32'h0000_0066, 0, 0); // bubble
        tbl[12] = mk(0, 1, 1, 0, 32'h0000_0077, MEMW,    5'd7,  0, 0, 3'b010, 5'd7,  32'h0000_0077, 0, 0); // no RegWrite
        tbl[13] = mk(0, 1, 1, 0, 32'h0000_ABCD, MEMW,    5'd12, 1, 0, 3'b010, 5'd12, 32'h0000_ABCD, 1, 0); // ADD before freeze
        tbl[14] = mk(0, 0, 1, 0, 32'h0000_DEAD, 32'h0,   5'd13, 1, 1, 3'b000, 5'd12, 32'h0000_ABCD, 1, 0); // frozen
        tbl[15] = mk(0, 0, 0, 0, 32'h0000_BEEF, 32'h0,   5'd14, 0, 0, 3'b100, 5'd12, 32'h0000_ABCD, 1, 0); // frozen

        // Reset, then three held cycles with garbage inputs: everything stays 0
        apply(mk(1, 1, 1, 0, 32'h1111_1111, MEMW, 5'd3, 1, 0, 3'b010, 5'd0, 32'h0, 0, 0), "reset");
        for (int i = 0; i < 3; i++)
            apply(mk(0, 0, 1, 0, 32'h2222_2222, MEMW, 5'd4, 1, 1, 3'b000, 5'd0, 32'h0, 0, 0),
                  $sformatf("hold%0d", i));
`ifdef WB_RETIRE_CNT_EN
        check("retired after reset", o_retired, 32'h0);
`endif

        for (int i = 0; i < 16; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // HALT sequence from a clean reset: ADD, HALT, ADD $9 (must never write)
        apply(mk(1, 1, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 3'b010, 5'd0, 32'h0, 0, 0), "halt_rst");
        apply(mk(0, 1, 1, 0, 32'h0000_0011, 32'h0, 5'd3, 1, 0, 3'b010, 5'd3, 32'h0000_0011, 1, 0), "halt_add");
        apply(mk(0, 1, 1, 1, 32'h0000_0000, 32'h0, 5'd0, 0, 0, 3'b010, 5'd0, 32'h0000_0000, 0, 0), "halt_slot");
        apply(mk(0, 1, 1, 0, 32'h0000_0099, 32'h0, 5'd9, 1, 0, 3'b010, 5'd9, 32'h0000_0099, 0, 1), "halt_add9");
        apply(mk(0, 1, 1, 0, 32'h0000_0077, 32'h0, 5'd6, 1, 0, 3'b010, 5'd9, 32'h0000_0099, 0, 1), "halt_frozen");
`ifdef WB_RETIRE_CNT_EN
        check("retired after halt", o_retired, 32'h1);
`endif

        // Same-edge reset and enable with a valid ADD present: reset wins, halt cleared
        apply(mk(1, 1, 1, 0, 32'h0000_0033, 32'h0, 5'd4, 1, 0, 3'b010, 5'd0, 32'h0, 0, 0), "rst_clears_halt");
`ifdef WB_RETIRE_CNT_EN
        check("retired cleared", o_retired, 32'h0);
`endif
        // Reset while a write is pending on the port
        apply(mk(0, 1, 1, 0, 32'h0000_0044, 32'h0, 5'd4, 1, 0, 3'b010, 5'd4, 32'h0000_0044, 1, 0), "pre_rst_add");
        apply(mk(1, 1, 1, 0, 32'h0000_0055, 32'h0, 5'd5, 1, 0, 3'b010, 5'd0, 32'h0, 0, 0), "rst_drop");
`ifdef WB_RETIRE_CNT_EN
        check("retired after drop", o_retired, 32'h0);
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard leftover: %0d entries", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_writeback.md
# stage_writeback

Final pipeline stage of the MIPS core: MEM/WB pipeline register plus writeback logic. Captures memory-stage results each enabled cycle, extracts and extends load data per access type, selects ALU result or load data, and drives the register-file write port consumed by the decode stage (`i_addr_data`, `i_data`, `i_RegWrite`). Also tracks halt retirement for the debug unit and optionally counts committed instructions.

## Interface
Parameters:
- `NB_DATA`, 32: data width. Only 32 is supported.
- `NB_ADDR`, 5: register address width.

Ports:
- `clk` in 1: clock, rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_enable` in 1: pipeline advance. 0 freezes the MEM/WB register.
- `i_valid` in 1: MEM-stage slot holds a real instruction. 0 means bubble.
- `i_alu_result` in 32: ALU result, also the memory byte address.
- `i_mem_data` in 32: raw data-memory word.
- `i_write_reg` in 5: destination register (rt or rd, already muxed).
- `is_RegWrite` in 1: write-enable control.
- `is_MemtoReg` in 1: 1 selects load data, 0 selects ALU result.
- `is_load_store_type` in 3: access type.
- `i_halt` in 1: the MEM slot holds HALT.
- `o_addr_data` out 5: register-file write address.
- `o_data` out 32: register-file write data.
- `os_RegWrite` out 1: register-file write enable.
- `o_halted` out 1: sticky, HALT has retired.
- `o_retired` out 32: committed-instruction count. Present only with `WB_RETIRE_CNT_EN`.

## Operation
- MEM/WB register fields: valid, alu_result, mem_data, write_reg, RegWrite, MemtoReg, load_store_type, halt. Reset clears every field to 0.
- Capture happens when `i_enable`=1 and `o_halted`=0. Otherwise all fields hold.
- Load extraction uses the registered `alu_result[1:0]` as `off`. Memory is little-endian: lane 0 is bits [7:0].
  - 3'b000 LB: byte at `off`, sign-extended.
  - 3'b100 LBU: byte at `off`, zero-extended.
  - 3'b001 LH: half selected by `off[1]`, sign-extended.
  - 3'b101 LHU: half selected by `off[1]`, zero-extended.
  - 3'b010 LW: full word. `off` is ignored.
  - Any other code: full word.
- `o_data` = registered MemtoReg ? extracted load : registered alu_result.
- `o_addr_data` = registered write_reg.
- `os_RegWrite` = reg valid & reg RegWrite & (write_reg ≠ 0) & ~`o_halted`. Writes to $0 are never issued.
- Halt:
  - When a captured slot has valid=1 and halt=1, `o_halted` goes to 1 on the following rising edge.
  - `o_halted` stays at 1 until `i_reset`.
  - HALT itself never writes.
- Decode-stage register file writes on this stage's outputs. Decode must be able to read the value in the same cycle; that requirement belongs to the register file, not this block.

## Timing
- Latency: MEM inputs appear on the write port exactly one `clk` after the capturing edge.
- Reset values: `o_addr_data`=0, `o_data`=0, `os_RegWrite`=0, `o_halted`=0, `o_retired`=0.
- Outputs are combinational from the MEM/WB register only. No input-to-output combinational path exists.
- `i_enable`=0: outputs hold their values. `os_RegWrite` stays asserted if it was asserted, so a repeated write of the same value is allowed.
- Same-edge reset and enable: reset wins.
- Reset mid-stream:
  - The pending write is dropped.
  - `os_RegWrite`=0 in the first cycle after the reset edge.
- `i_valid`=0 with `is_RegWrite`=1: no write.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - `o_retired` increments by 1 at each rising edge where reset=0, `i_enable`=1, `o_halted`=0, registered valid=1, and registered halt=0.
  - The counter wraps from 0xFFFFFFFF to 0.
  - HALT itself is not counted.
- `WB_RETIRE_CNT_EN` not defined: the port and the counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then hold the design for 3 cycles: all outputs stay 0.
- ADD result case: `i_alu_result`=0x0000_1234, `i_write_reg`=8, `is_RegWrite`=1, `is_MemtoReg`=0, `i_valid`=1. Required response, one cycle later: `o_addr_data`=8, `o_data`=0x0000_1234, `os_RegWrite`=1.
- Load extraction with `i_mem_data`=0x80FF_7F01, `is_MemtoReg`=1:
  - LB, `off`=3 → 0xFFFF_FF80.
  - LBU, `off`=3 → 0x0000_0080.
  - LH, `off`=2 → 0xFFFF_80FF.
  - LHU, `off`=0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- Suppression cases:
  - `i_write_reg`=0 with `is_RegWrite`=1 → `os_RegWrite`=0.
  - `i_valid`=0 → `os_RegWrite`=0.
  - `i_enable`=0 for 2 cycles → outputs unchanged.
- HALT sequence: send an ADD, then HALT, then an ADD to $9.
  - `o_halted`=1 two edges after HALT is presented.
  - The $9 write never appears.
  - With `WB_RETIRE_CNT_EN`, `o_retired`=1.
- Reset pulse while `os_RegWrite`=1: `os_RegWrite`=0 next cycle, `o_halted` cleared, counter back to 0.
